// File: rtl/clcd_bus_receiver.sv
// Shadow receiver for the HD44780-style E/RS/DATA write bus: 2xCOLS DDRAM mirror plus cursor/display state.
// Optional CGRAM shadow and its read port are enabled by defining CLCD_CGRAM_EN.
module clcd_bus_receiver #(
  parameter int COLS        = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CLR_CYCLES  = 32
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic [7:0] LCD_DATA,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_CHAR,
  output logic [6:0] CUR_ADDR,
  output logic       DISP_ON,
  output logic       BUSY,
  output logic       CMD_STB,
  output logic       CHAR_STB,
  output logic       ERR_STB
`ifdef CLCD_CGRAM_EN
  ,
  input  logic [5:0] CG_RD_ADDR,
  output logic [4:0] CG_RD_DATA
`endif
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int NW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
  state_t state_q, state_d;

  logic [9:0]    sync_q [SYNC_STAGES];
  logic [9:0]    prev_q;
  logic          xfer_vld;
  logic          xfer_rs;
  logic [7:0]    xfer_data;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [6:0]    addr_q, addr_d;
  logic          disp_q, disp_d, inc_q, inc_d, cg_q, cg_d;
  logic          cmd_d, char_d, err_d;
  logic          dd_we, dd_row;
  logic [CW-1:0] dd_col;
  logic [7:0]    dd_wdata;
  logic [7:0]    ddram [2][COLS];
  logic [7:0]    rd_word;

  // Address step shared by data writes and cursor-move commands.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic cg, input logic inc);
    if (cg) return {1'b0, inc ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
    if (inc) return (a[5:0] >= 6'h27) ? {~a[6], 6'h00} : a + 7'd1;
    return (a[5:0] == 6'h00) ? {~a[6], 6'h27} : a - 7'd1;
  endfunction

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q    <= '0;
      xfer_vld  <= 1'b0;
      xfer_rs   <= 1'b0;
      xfer_data <= '0;
    end else begin
      sync_q[0] <= {LCD_E, LCD_RS, LCD_DATA};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q    <= sync_q[SYNC_STAGES-1];
      // RS/DATA come from the last sample that still had E high.
      xfer_vld  <= prev_q[9] & ~sync_q[SYNC_STAGES-1][9];
      xfer_rs   <= prev_q[8];
      xfer_data <= prev_q[7:0];
    end
  end

`ifdef CLCD_CGRAM_EN
  logic       cg_we;
  logic [4:0] cgram [64];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    disp_d   = disp_q;
    inc_d    = inc_q;
    cg_d     = cg_q;
    cmd_d    = 1'b0;
    char_d   = 1'b0;
    err_d    = 1'b0;
    dd_we    = 1'b0;
    dd_row   = 1'b0;
    dd_col   = '0;
    dd_wdata = 8'h20;
`ifdef CLCD_CGRAM_EN
    cg_we    = 1'b0;
`endif
    if (state_q == ST_CLEAR) begin
      if (int'(cnt_q) < 2 * COLS) begin
        dd_we  = 1'b1;
        dd_row = (int'(cnt_q) >= COLS);
        dd_col = CW'(int'(cnt_q) % COLS);
      end
      if (cnt_q == NW'(CLR_CYCLES - 1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      err_d = xfer_vld;
    end else if (xfer_vld) begin
      if (!xfer_rs) begin
        cmd_d = 1'b1;
        if (xfer_data[7]) begin
          addr_d = xfer_data[6:0];
          cg_d   = 1'b0;
        end else if (xfer_data[6]) begin
          addr_d = {1'b0, xfer_data[5:0]};
          cg_d   = 1'b1;
        end else if (xfer_data[5]) begin
          addr_d = addr_q;
        end else if (xfer_data[4]) begin
          if (!xfer_data[3]) addr_d = step_addr(addr_q, cg_q, xfer_data[2]);
        end else if (xfer_data[3]) begin
          disp_d = xfer_data[2];
        end else if (xfer_data[2]) begin
          inc_d = xfer_data[1];
        end else if (xfer_data[1]) begin
          addr_d = '0;
          cg_d   = 1'b0;
        end else if (xfer_data[0]) begin
          addr_d  = '0;
          inc_d   = 1'b1;
          cg_d    = 1'b0;
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end else begin
        char_d = 1'b1;
        addr_d = step_addr(addr_q, cg_q, inc_q);
        if (cg_q) begin
`ifdef CLCD_CGRAM_EN
          cg_we = 1'b1;
`endif
        end else if (addr_q[5:0] < 6'(COLS)) begin
          dd_we    = 1'b1;
          dd_row   = addr_q[6];
          dd_col   = addr_q[CW-1:0];
          dd_wdata = xfer_data;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      addr_q   <= '0;
      disp_q   <= 1'b0;
      inc_q    <= 1'b1;
      cg_q     <= 1'b0;
      CMD_STB  <= 1'b0;
      CHAR_STB <= 1'b0;
      ERR_STB  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      disp_q   <= disp_d;
      inc_q    <= inc_d;
      cg_q     <= cg_d;
      CMD_STB  <= cmd_d;
      CHAR_STB <= char_d;
      ERR_STB  <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (dd_we) ddram[dd_row][dd_col] <= dd_wdata;
  end

  // RD_ADDR carries a 4-bit column, so COLS is at most 16.
  generate
    if (COLS >= 16) begin : g_full_row
      assign rd_word = ddram[RD_ADDR[4]][RD_ADDR[3:0]];
    end else begin : g_part_row
      assign rd_word = (RD_ADDR[3:0] < 4'(COLS)) ? ddram[RD_ADDR[4]][RD_ADDR[CW-1:0]] : 8'h20;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) RD_CHAR <= 8'h00;
    else         RD_CHAR <= rd_word;
  end

`ifdef CLCD_CGRAM_EN
  always_ff @(posedge CLK) begin
    if (cg_we) cgram[addr_q[5:0]] <= xfer_data[4:0];
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) CG_RD_DATA <= 5'd0;
    else         CG_RD_DATA <= cgram[CG_RD_ADDR];
  end
`endif

  assign CUR_ADDR = addr_q;
  assign DISP_ON  = disp_q;
  assign BUSY     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_clcd_bus_receiver.sv
// Bench for clcd_bus_receiver: bus-level driver, transfer-level reference model, strobe monitor with expected queue.
module tb_clcd_bus_receiver;

  logic       CLK, RESETN, LCD_E, LCD_RS;
  logic [7:0] LCD_DATA;
  logic [4:0] RD_ADDR;
  logic [7:0] RD_CHAR;
  logic [6:0] CUR_ADDR;
  logic       DISP_ON, BUSY, CMD_STB, CHAR_STB, ERR_STB;
`ifdef CLCD_CGRAM_EN
  logic [5:0] CG_RD_ADDR;
  logic [4:0] CG_RD_DATA;
`endif

  clcd_bus_receiver dut (
    .CLK(CLK), .RESETN(RESETN), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_DATA(LCD_DATA),
    .RD_ADDR(RD_ADDR), .RD_CHAR(RD_CHAR), .CUR_ADDR(CUR_ADDR), .DISP_ON(DISP_ON),
    .BUSY(BUSY), .CMD_STB(CMD_STB), .CHAR_STB(CHAR_STB), .ERR_STB(ERR_STB)
`ifdef CLCD_CGRAM_EN
    , .CG_RD_ADDR(CG_RD_ADDR), .CG_RD_DATA(CG_RD_DATA)
`endif
  );

  // Expected entry per transfer: {cmd_stb, char_stb, err_stb, cur_addr[6:0], disp_on}
  logic [10:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_addr;
  logic       m_disp, m_inc, m_cg, m_busy;
  logic [7:0] m_dd [32];
  logic [7:0] clock_str [8] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36};

  // clock/reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // model
  task automatic model_reset();
    m_addr = 0; m_disp = 1'b0; m_inc = 1'b1; m_cg = 1'b0; m_busy = 1'b1;
  endtask

  task automatic model_fill();
    for (int i = 0; i < 32; i++) m_dd[i] = 8'h20;
    m_busy = 1'b0;
  endtask

  task automatic model_move(input logic up);
    int row, col;
    if (m_cg) begin
      m_addr = up ? (m_addr + 1) % 64 : (m_addr + 63) % 64;
    end else begin
      row = m_addr / 64;
      col = m_addr % 64;
      if (up) m_addr = (col >= 39) ? (1 - row) * 64 : m_addr + 1;
      else    m_addr = (col == 0) ? (1 - row) * 64 + 39 : m_addr - 1;
    end
  endtask

  task automatic model_xfer(input logic rs, input logic [7:0] d, output logic [10:0] e);
    int hb, col;
    logic err;
    if (m_busy) begin
      e = {3'b001, 7'(m_addr), m_disp};
    end else if (!rs) begin
      hb = -1;
      for (int b = 7; b >= 0; b--) if (d[b] && hb < 0) hb = b;
      case (hb)
        7: begin m_addr = int'(d) - 128; m_cg = 1'b0; end
        6: begin m_addr = int'(d) - 64; m_cg = 1'b1; end
        4: if (!d[3]) model_move(d[2]);
        3: m_disp = d[2];
        2: m_inc = d[1];
        1: begin m_addr = 0; m_cg = 1'b0; end
        0: begin m_addr = 0; m_inc = 1'b1; m_cg = 1'b0; m_busy = 1'b1; end
        default: ;
      endcase
      e = {3'b100, 7'(m_addr), m_disp};
    end else begin
      err = 1'b0;
      col = m_addr % 64;
      if (!m_cg) begin
        if (col < 16) m_dd[(m_addr / 64) * 16 + col] = d;
        else err = 1'b1;
      end
      model_move(m_inc);
      e = {2'b01, err, 7'(m_addr), m_disp};
    end
  endtask

  // driver tasks
  task automatic send(input logic rs, input logic [7:0] d);
    logic [10:0] e;
    model_xfer(rs, d, e);
    exp_q.push_back(e);
    @(negedge CLK);
    LCD_RS = rs; LCD_DATA = d; LCD_E = 1'b1;
    repeat (4) @(negedge CLK);
    LCD_E = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic read_cell(input int a, output logic [7:0] v);
    @(negedge CLK);
    RD_ADDR = 5'(a);
    @(negedge CLK);
    v = RD_CHAR;
  endtask

  task automatic check_all_cells(input string name);
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      check(name, {24'd0, v}, {24'd0, m_dd[i]});
    end
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (BUSY === 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("busy_release", {31'd0, BUSY}, 32'd0);
    model_fill();
  endtask

  task automatic check_reset_state();
    check("rst_rd_char", {24'd0, RD_CHAR}, 32'h00);
    check("rst_cur_addr", {25'd0, CUR_ADDR}, 32'h00);
    check("rst_flags", {28'd0, DISP_ON, CMD_STB, CHAR_STB, ERR_STB}, 32'h0);
    check("rst_busy", {31'd0, BUSY}, 32'd1);
  endtask

  task automatic release_and_fill();
    int n = 0;
    @(negedge CLK);
    RESETN = 1'b1;
    while (BUSY === 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("busy_cycles", n, 32);
    model_fill();
    check_all_cells("fill_cell");
    check("post_fill_addr", {25'd0, CUR_ADDR}, 32'h00);
    check("post_fill_disp", {31'd0, DISP_ON}, 32'd0);
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    if (RESETN && (CMD_STB || CHAR_STB || ERR_STB)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {21'd0, CMD_STB, CHAR_STB, ERR_STB, CUR_ADDR, DISP_ON}, 32'h7FF);
      end else begin
        check("xfer_response", {21'd0, CMD_STB, CHAR_STB, ERR_STB, CUR_ADDR, DISP_ON},
              {21'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] v, d;
    RESETN = 1'b0; LCD_E = 1'b0; LCD_RS = 1'b0; LCD_DATA = 8'h00; RD_ADDR = 5'd0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_reset_state();
    release_and_fill();

    // clock string in row 0
    send(1'b0, 8'h80);
    for (int i = 0; i < 8; i++) send(1'b1, clock_str[i]);
    for (int i = 0; i < 8; i++) begin
      read_cell(i, v);
      check("clock_str", {24'd0, v}, {24'd0, clock_str[i]});
    end
    check("addr_after_str", {25'd0, CUR_ADDR}, 32'h08);

    // row 1 write and display on
    send(1'b0, 8'hC0);
    send(1'b1, 8'h41);
    read_cell(16, v);
    check("row1_cell0", {24'd0, v}, 32'h41);
    send(1'b0, 8'h0C);
    check("disp_on", {31'd0, DISP_ON}, 32'd1);

    // out-of-window write and decrement wrap
    send(1'b0, 8'hA7);
    send(1'b1, 8'h78);
    check("wrap_inc_addr", {25'd0, CUR_ADDR}, 32'h40);
    send(1'b0, 8'h04);
    send(1'b0, 8'h80);
    send(1'b1, 8'h79);
    check("wrap_dec_addr", {25'd0, CUR_ADDR}, 32'h67);
    send(1'b0, 8'h06);
    check_all_cells("dir_cell");

    // transfer dropped while clearing
    send(1'b0, 8'h01);
    send(1'b1, 8'h5A);
    wait_not_busy();
    read_cell(0, v);
    check("clear_cell0", {24'd0, v}, 32'h20);
    send(1'b1, 8'h5A);
    read_cell(0, v);
    check("z_cell0", {24'd0, v}, 32'h5A);

    // randomized transfers
    for (int k = 0; k < 160; k++) begin
      case ($urandom_range(0, 11))
        0:       send(1'b0, {1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 20))});
        1:       send(1'b0, {1'b1, 7'($urandom_range(0, 127))});
        2:       send(1'b0, {2'b01, 6'($urandom_range(0, 63))});
        3:       send(1'b0, {4'b0001, 4'($urandom_range(0, 15))});
        4:       send(1'b0, {5'b00001, 3'($urandom_range(0, 7))});
        5:       send(1'b0, {6'b000001, 2'($urandom_range(0, 3))});
        6: begin
          d = 8'($urandom_range(2, 255));
          send(1'b0, d);
        end
        7:       if ($urandom_range(0, 5) == 0) send(1'b0, 8'h01);
                 else send(1'b0, {7'b0000001, 1'($urandom_range(0, 1))});
        default: send(1'b1, 8'($urandom_range(0, 255)));
      endcase
      if (m_busy) wait_not_busy();
    end
    check_all_cells("rand_cell");

    // reset in the middle of a clear after row 1 was written
    send(1'b0, 8'hC0);
    for (int i = 0; i < 6; i++) send(1'b1, 8'($urandom_range(33, 126)));
    send(1'b0, 8'h01);
    repeat (5) @(negedge CLK);
    RESETN = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge CLK);
    check_reset_state();
    release_and_fill();

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
